// File: rtl/word_gen_range_ctrl.sv
// Configuration loader and generation sequencer for a chain of word_gen_char_range instances.
// Parses range descriptors, drives per-range config strobes, then steps op_state until the top range wraps.
module word_gen_range_ctrl #(
    parameter int CHAR_BITS            = 7,
    parameter int CHARS_NUMBER_MAX     = (CHAR_BITS == 8) ? 224 : 96,
    parameter int RANGES_MAX           = 8,
    parameter int EXTRA_REGISTER_STAGE = 0,
    parameter int WORD_CNT_WIDTH       = 32
) (
    input  logic                      CLK,
    input  logic                      RESET_N,
    input  logic [7:0]                din,
    input  logic                      din_wr_en,
    output logic                      din_ready,
    output logic [CHAR_BITS-1:0]      conf_din,
    output logic [RANGES_MAX-1:0]     conf_en_num_chars,
    output logic                      num_chars_eq0,
    output logic                      num_chars_lt2,
    output logic [RANGES_MAX-1:0]     conf_en_start_idx,
    output logic                      start_idx_is_end,
    output logic [RANGES_MAX-1:0]     conf_en_chars,
    output logic [CHAR_BITS-1:0]      conf_char_addr,
    output logic                      pre_end_char,
    output logic [2:0]                op_state,
    output logic                      op_en,
    output logic                      carry_first,
    input  logic                      carry_last,
    input  logic                      word_ready,
    output logic                      word_valid,
    output logic                      op_done_sync,
    output logic [WORD_CNT_WIDTH-1:0] word_count,
    output logic                      error
);

    typedef enum logic [3:0] {
        S_IDLE, S_NUM_CHARS, S_START_IDX, S_CHARS, S_CFG_END,
        S_OP_START, S_OP_EXTRA, S_RUN, S_DONE, S_ERR
    } state_e;

    typedef enum logic [2:0] {
        OP_READY       = 3'd0,
        OP_START       = 3'd1,
        OP_EXTRA_STAGE = 3'd2,
        OP_NEXT_CHAR   = 3'd3,
        OP_NEXT_WORD   = 3'd4
    } op_state_e;

    localparam logic [8:0] RANGES_LIM = 9'(RANGES_MAX);
    localparam logic [8:0] CHARS_LIM  = 9'(CHARS_NUMBER_MAX);

    state_e                    state_q, state_d;
    logic                      din_ready_q, din_ready_d;
    logic [CHAR_BITS-1:0]      conf_din_q, conf_din_d;
    logic [RANGES_MAX-1:0]     en_num_q, en_num_d;
    logic                      eq0_q, eq0_d, lt2_q, lt2_d;
    logic [RANGES_MAX-1:0]     en_start_q, en_start_d;
    logic                      is_end_q, is_end_d;
    logic [RANGES_MAX-1:0]     en_chars_q, en_chars_d;
    logic [CHAR_BITS-1:0]      char_addr_q, char_addr_d;
    logic                      pre_end_q, pre_end_d;
    logic                      error_q, error_d;
    logic [WORD_CNT_WIDTH-1:0] word_count_q, word_count_d;
    logic [7:0]                n_ranges_q, n_ranges_d;
    logic [7:0]                range_q, range_d;
    logic [7:0]                num_chars_q, num_chars_d;
    logic [7:0]                char_idx_q, char_idx_d;

    logic                      accept;
    logic                      run_en;
    logic [RANGES_MAX-1:0]     range_onehot;
    logic [7:0]                range_inc;
    logic [7:0]                char_inc;
    logic                      more_ranges;

    assign accept      = din_wr_en & din_ready_q;
    assign run_en      = (state_q == S_RUN) & word_ready;
    assign range_inc   = range_q + 8'd1;
    assign char_inc    = char_idx_q + 8'd1;
    assign more_ranges = (range_inc < n_ranges_q);

    always_comb begin
        range_onehot = '0;
        for (int unsigned i = 0; i < RANGES_MAX; i++) begin
            range_onehot[i] = (range_q == 8'(i));
        end
    end

    always_comb begin
        state_d      = state_q;
        conf_din_d   = conf_din_q;
        en_num_d     = '0;
        eq0_d        = 1'b0;
        lt2_d        = 1'b0;
        en_start_d   = '0;
        is_end_d     = 1'b0;
        en_chars_d   = '0;
        char_addr_d  = char_addr_q;
        pre_end_d    = 1'b0;
        error_d      = error_q;
        word_count_d = word_count_q;
        n_ranges_d   = n_ranges_q;
        range_d      = range_q;
        num_chars_d  = num_chars_q;
        char_idx_d   = char_idx_q;

        if (accept) begin
            conf_din_d = din[CHAR_BITS-1:0];
        end

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    word_count_d = '0;
                    if (din == 8'd0 || {1'b0, din} > RANGES_LIM) begin
                        error_d = 1'b1;
                        state_d = S_ERR;
                    end else begin
                        n_ranges_d = din;
                        range_d    = '0;
                        state_d    = S_NUM_CHARS;
                    end
                end
            end
            S_NUM_CHARS: begin
                if (accept) begin
                    if ({1'b0, din} > CHARS_LIM) begin
                        error_d = 1'b1;
                        state_d = S_ERR;
                    end else begin
                        en_num_d    = range_onehot;
                        eq0_d       = (din == 8'd0);
                        lt2_d       = (din < 8'd2);
                        num_chars_d = din;
                        // An empty range carries no start_idx or char bytes.
                        if (din == 8'd0) begin
                            if (more_ranges) begin
                                range_d = range_inc;
                            end else begin
                                state_d = S_CFG_END;
                            end
                        end else begin
                            state_d = S_START_IDX;
                        end
                    end
                end
            end
            S_START_IDX: begin
                if (accept) begin
                    if (din >= num_chars_q) begin
                        error_d = 1'b1;
                        state_d = S_ERR;
                    end else begin
                        en_start_d = range_onehot;
                        is_end_d   = (din == num_chars_q - 8'd1);
                        char_idx_d = '0;
                        state_d    = S_CHARS;
                    end
                end
            end
            S_CHARS: begin
                if (accept) begin
                    en_chars_d  = range_onehot;
                    char_addr_d = char_idx_q[CHAR_BITS-1:0];
                    pre_end_d   = ({1'b0, char_idx_q} + 9'd2 == {1'b0, num_chars_q});
                    if (char_inc == num_chars_q) begin
                        if (more_ranges) begin
                            range_d = range_inc;
                            state_d = S_NUM_CHARS;
                        end else begin
                            state_d = S_CFG_END;
                        end
                    end else begin
                        char_idx_d = char_inc;
                    end
                end
            end
            S_CFG_END:  state_d = S_OP_START;
            S_OP_START: state_d = (EXTRA_REGISTER_STAGE != 0) ? S_OP_EXTRA : S_RUN;
            S_OP_EXTRA: state_d = S_RUN;
            S_RUN: begin
                if (run_en) begin
                    if (word_count_q != '1) begin
                        word_count_d = word_count_q + 1'b1;
                    end
                    if (carry_last) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            S_ERR:   state_d = S_ERR;
            default: state_d = S_IDLE;
        endcase

        din_ready_d = (state_d == S_IDLE) || (state_d == S_NUM_CHARS) ||
                      (state_d == S_START_IDX) || (state_d == S_CHARS);
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q      <= S_IDLE;
            din_ready_q  <= 1'b0;
            conf_din_q   <= '0;
            en_num_q     <= '0;
            eq0_q        <= 1'b0;
            lt2_q        <= 1'b0;
            en_start_q   <= '0;
            is_end_q     <= 1'b0;
            en_chars_q   <= '0;
            char_addr_q  <= '0;
            pre_end_q    <= 1'b0;
            error_q      <= 1'b0;
            word_count_q <= '0;
            n_ranges_q   <= '0;
            range_q      <= '0;
            num_chars_q  <= '0;
            char_idx_q   <= '0;
        end else begin
            state_q      <= state_d;
            din_ready_q  <= din_ready_d;
            conf_din_q   <= conf_din_d;
            en_num_q     <= en_num_d;
            eq0_q        <= eq0_d;
            lt2_q        <= lt2_d;
            en_start_q   <= en_start_d;
            is_end_q     <= is_end_d;
            en_chars_q   <= en_chars_d;
            char_addr_q  <= char_addr_d;
            pre_end_q    <= pre_end_d;
            error_q      <= error_d;
            word_count_q <= word_count_d;
            n_ranges_q   <= n_ranges_d;
            range_q      <= range_d;
            num_chars_q  <= num_chars_d;
            char_idx_q   <= char_idx_d;
        end
    end

    always_comb begin
        case (state_q)
            S_OP_START: op_state = OP_START;
            S_OP_EXTRA: op_state = OP_EXTRA_STAGE;
            S_RUN:      op_state = OP_NEXT_CHAR;
            default:    op_state = OP_READY;
        endcase
    end

    assign din_ready         = din_ready_q;
    assign conf_din          = conf_din_q;
    assign conf_en_num_chars = en_num_q;
    assign num_chars_eq0     = eq0_q;
    assign num_chars_lt2     = lt2_q;
    assign conf_en_start_idx = en_start_q;
    assign start_idx_is_end  = is_end_q;
    assign conf_en_chars     = en_chars_q;
    assign conf_char_addr    = char_addr_q;
    assign pre_end_char      = pre_end_q;
    assign op_en             = run_en;
    assign word_valid        = run_en;
    assign carry_first       = 1'b1;
    assign op_done_sync      = (state_q == S_DONE);
    assign word_count        = word_count_q;
    assign error             = error_q;

endmodule

// File: tb/tb_word_gen_range_ctrl.sv
// Directed bench for word_gen_range_ctrl: config parsing, run gating, errors and async reset.
// carry_last comes from a small word counter standing in for the top range's wrap.
module tb_word_gen_range_ctrl;

    logic        CLK;
    logic        RESET_N;
    logic [7:0]  din;
    logic        din_wr_en;
    logic        din_ready;
    logic [6:0]  conf_din;
    logic [7:0]  conf_en_num_chars;
    logic        num_chars_eq0;
    logic        num_chars_lt2;
    logic [7:0]  conf_en_start_idx;
    logic        start_idx_is_end;
    logic [7:0]  conf_en_chars;
    logic [6:0]  conf_char_addr;
    logic        pre_end_char;
    logic [2:0]  op_state;
    logic        op_en;
    logic        carry_first;
    logic        carry_last;
    logic        word_ready;
    logic        word_valid;
    logic        op_done_sync;
    logic [31:0] word_count;
    logic        error;

    int n_eval = 0;
    int n_fail = 0;
    int target = 1;
    int mcnt;

    word_gen_range_ctrl #(
        .CHAR_BITS(7),
        .CHARS_NUMBER_MAX(96),
        .RANGES_MAX(8),
        .EXTRA_REGISTER_STAGE(0),
        .WORD_CNT_WIDTH(32)
    ) dut (
        .CLK(CLK), .RESET_N(RESET_N), .din(din), .din_wr_en(din_wr_en), .din_ready(din_ready),
        .conf_din(conf_din), .conf_en_num_chars(conf_en_num_chars), .num_chars_eq0(num_chars_eq0),
        .num_chars_lt2(num_chars_lt2), .conf_en_start_idx(conf_en_start_idx),
        .start_idx_is_end(start_idx_is_end), .conf_en_chars(conf_en_chars),
        .conf_char_addr(conf_char_addr), .pre_end_char(pre_end_char), .op_state(op_state),
        .op_en(op_en), .carry_first(carry_first), .carry_last(carry_last), .word_ready(word_ready),
        .word_valid(word_valid), .op_done_sync(op_done_sync), .word_count(word_count), .error(error)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Top range wraps on the target-th generated word.
    always @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N)               mcnt <= 0;
        else if (op_state != 3'd3)  mcnt <= 0;
        else if (op_en)             mcnt <= mcnt + 1;
    end
    assign carry_last = (op_state == 3'd3) && (mcnt == target - 1);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_eval++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] b);
        chk("din_ready_at_send", {31'd0, din_ready}, 32'd1);
        din       = b;
        din_wr_en = 1'b1;
        @(negedge CLK);
        din_wr_en = 1'b0;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_strobes"}, {8'd0, conf_en_num_chars, conf_en_start_idx, conf_en_chars}, 32'd0);
        chk({tag, "_quals"}, {28'd0, num_chars_eq0, num_chars_lt2, start_idx_is_end, pre_end_char}, 32'd0);
        chk({tag, "_din_addr"}, {18'd0, conf_din, conf_char_addr}, 32'd0);
        chk({tag, "_ready_err"}, {30'd0, din_ready, error}, 32'd0);
        chk({tag, "_op"}, {27'd0, op_state, op_en, op_done_sync}, 32'd0);
        chk({tag, "_wc"}, word_count, 32'd0);
    endtask

    task automatic run_until_done(input int tgt, output int ops, output bit done);
        target = tgt;
        ops    = 0;
        done   = 1'b0;
        for (int i = 0; i < 64 && !done; i++) begin
            if (op_done_sync) done = 1'b1;
            else begin
                if (op_en) ops++;
                @(negedge CLK);
            end
        end
    endtask

    task automatic run_abc();
        int  ops;
        bit  done;
        send(8'd1);
        chk("abc_no_strobe_on_N", {24'd0, conf_en_num_chars}, 32'd0);
        send(8'd3);
        chk("abc_en_num", {24'd0, conf_en_num_chars}, 32'h01);
        chk("abc_eq0_lt2", {30'd0, num_chars_eq0, num_chars_lt2}, 32'd0);
        chk("abc_conf_din_n", {25'd0, conf_din}, 32'd3);
        send(8'd0);
        chk("abc_en_start", {24'd0, conf_en_start_idx}, 32'h01);
        chk("abc_is_end", {31'd0, start_idx_is_end}, 32'd0);
        chk("abc_en_num_gone", {24'd0, conf_en_num_chars}, 32'd0);
        send(8'h61);
        chk("abc_c0", {conf_en_chars, 1'b0, conf_char_addr, 7'd0, pre_end_char, 1'b0, conf_din}, {8'h01, 1'b0, 7'd0, 7'd0, 1'b0, 1'b0, 7'h61});
        send(8'h62);
        chk("abc_c1", {conf_en_chars, 1'b0, conf_char_addr, 7'd0, pre_end_char, 1'b0, conf_din}, {8'h01, 1'b0, 7'd1, 7'd0, 1'b1, 1'b0, 7'h62});
        send(8'h63);
        chk("abc_c2", {conf_en_chars, 1'b0, conf_char_addr, 7'd0, pre_end_char, 1'b0, conf_din}, {8'h01, 1'b0, 7'd2, 7'd0, 1'b0, 1'b0, 7'h63});
        chk("abc_ready_low_after_cfg", {31'd0, din_ready}, 32'd0);
        chk("abc_op_ready_t1", {29'd0, op_state}, 32'd0);
        word_ready = 1'b1;
        target     = 3;
        @(negedge CLK);
        chk("abc_op_start_t2", {29'd0, op_state}, 32'd1);
        chk("abc_no_op_en_start", {31'd0, op_en}, 32'd0);
        @(negedge CLK);
        chk("abc_op_run", {29'd0, op_state}, 32'd3);
        run_until_done(3, ops, done);
        chk("abc_done_seen", {31'd0, done}, 32'd1);
        chk("abc_op_en_cycles", ops, 32'd3);
        chk("abc_word_count", word_count, 32'd3);
        chk("abc_op_state_done", {29'd0, op_state}, 32'd0);
        @(negedge CLK);
        chk("abc_done_one_cycle", {31'd0, op_done_sync}, 32'd0);
        chk("abc_back_idle", {31'd0, din_ready}, 32'd1);
        chk("abc_wc_hold", word_count, 32'd3);
        word_ready = 1'b0;
    endtask

    initial begin : main
        int   ops;
        bit   done;
        int   ewc;
        logic wr [4];
        wr[0] = 1'b1; wr[1] = 1'b0; wr[2] = 1'b0; wr[3] = 1'b1;

        RESET_N    = 1'b0;
        din        = '0;
        din_wr_en  = 1'b0;
        word_ready = 1'b0;
        repeat (2) @(negedge CLK);
        chk_reset("por");
        chk("carry_first", {31'd0, carry_first}, 32'd1);
        RESET_N = 1'b1;
        #1;
        chk("ready_low_before_clk", {31'd0, din_ready}, 32'd0);
        @(negedge CLK);
        chk("ready_after_clk", {31'd0, din_ready}, 32'd1);

        run_abc();

        // Two ranges, then word_ready gating 1,0,0,1
        send(8'd2);
        chk("n2_wc_clear", word_count, 32'd0);
        send(8'd2);
        chk("n2_r0_num", {22'd0, conf_en_num_chars, num_chars_eq0, num_chars_lt2}, {22'd0, 8'h01, 1'b0, 1'b0});
        send(8'd1);
        chk("n2_r0_start", {23'd0, conf_en_start_idx, start_idx_is_end}, {23'd0, 8'h01, 1'b1});
        send(8'h78);
        chk("n2_r0_c0", {15'd0, conf_en_chars, conf_char_addr, pre_end_char, 1'b0}, {15'd0, 8'h01, 7'd0, 1'b1, 1'b0});
        send(8'h79);
        chk("n2_r0_c1", {15'd0, conf_en_chars, conf_char_addr, pre_end_char, 1'b0}, {15'd0, 8'h01, 7'd1, 1'b0, 1'b0});
        send(8'd1);
        chk("n2_r1_num", {22'd0, conf_en_num_chars, num_chars_eq0, num_chars_lt2}, {22'd0, 8'h02, 1'b0, 1'b1});
        send(8'd0);
        chk("n2_r1_start", {23'd0, conf_en_start_idx, start_idx_is_end}, {23'd0, 8'h02, 1'b1});
        send(8'h7a);
        chk("n2_r1_c0", {15'd0, conf_en_chars, conf_char_addr, pre_end_char, 1'b0}, {15'd0, 8'h02, 7'd0, 1'b0, 1'b0});
        target = 2;
        for (int i = 0; i < 8 && op_state != 3'd3; i++) @(negedge CLK);
        chk("n2_reach_run", {29'd0, op_state}, 32'd3);
        ewc = 0;
        for (int k = 0; k < 4; k++) begin
            chk("gate_wc", word_count, ewc);
            word_ready = wr[k];
            #1;
            chk("gate_op_en", {30'd0, op_en, word_valid}, {30'd0, wr[k], wr[k]});
            @(negedge CLK);
            ewc += int'(wr[k]);
        end
        chk("gate_wc_final", word_count, 32'd2);
        chk("gate_done", {31'd0, op_done_sync}, 32'd1);
        word_ready = 1'b0;
        @(negedge CLK);

        // Empty first range: next num_chars byte follows immediately
        send(8'd2);
        send(8'd0);
        chk("n0_num", {22'd0, conf_en_num_chars, num_chars_eq0, num_chars_lt2}, {22'd0, 8'h01, 1'b1, 1'b1});
        send(8'd1);
        chk("n0_next_range", {14'd0, conf_en_num_chars, conf_en_start_idx, num_chars_eq0, num_chars_lt2}, {14'd0, 8'h02, 8'h00, 1'b0, 1'b1});
        send(8'd0);
        chk("n0_r1_start", {23'd0, conf_en_start_idx, start_idx_is_end}, {23'd0, 8'h02, 1'b1});
        send(8'h71);
        chk("n0_r1_c0", {16'd0, conf_en_chars, 1'b0, conf_char_addr}, {16'd0, 8'h02, 1'b0, 7'd0});
        word_ready = 1'b1;
        run_until_done(1, ops, done);
        chk("n0_done", {31'd0, done}, 32'd1);
        chk("n0_ops", ops, 32'd1);
        chk("n0_wc", word_count, 32'd1);
        word_ready = 1'b0;
        @(negedge CLK);

        // N beyond RANGES_MAX
        send(8'd9);
        chk("errN_flags", {30'd0, error, din_ready}, {30'd0, 1'b1, 1'b0});
        chk("errN_no_strobe", {8'd0, conf_en_num_chars, conf_en_start_idx, conf_en_chars}, 32'd0);
        din       = 8'd1;
        din_wr_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            chk("errN_stuck", {6'd0, conf_en_num_chars, conf_en_start_idx, conf_en_chars, error, din_ready}, {6'd0, 24'd0, 1'b1, 1'b0});
        end
        din_wr_en = 1'b0;
        RESET_N   = 1'b0;
        #1;
        chk("errN_reset_clears", {31'd0, error}, 32'd0);
        @(negedge CLK);
        RESET_N = 1'b1;
        @(negedge CLK);

        // start_idx equal to num_chars
        send(8'd1);
        send(8'd2);
        chk("errS_num_ok", {24'd0, conf_en_num_chars}, 32'h01);
        send(8'd2);
        chk("errS_flags", {22'd0, conf_en_start_idx, error, din_ready}, {22'd0, 8'h00, 1'b1, 1'b0});
        @(negedge CLK);
        chk("errS_sticky", {31'd0, error}, 32'd1);
        RESET_N = 1'b0;
        #1;
        chk("errS_reset_clears", {31'd0, error}, 32'd0);
        @(negedge CLK);
        RESET_N = 1'b1;
        @(negedge CLK);

        // Async reset while a char strobe is live, then a clean reload
        send(8'd1);
        send(8'd3);
        send(8'd0);
        send(8'h61);
        chk("mid_char_strobe", {24'd0, conf_en_chars}, 32'h01);
        RESET_N = 1'b0;
        #1;
        chk_reset("mid");
        @(negedge CLK);
        RESET_N = 1'b1;
        @(negedge CLK);
        chk("mid_ready_again", {31'd0, din_ready}, 32'd1);
        run_abc();

        $display("End of test - %0d assertions evaluated, %0d failures", n_eval, n_fail);
        $finish;
    end

endmodule

// File: doc/word_gen_range_ctrl.md
# word_gen_range_ctrl

Configuration loader and generation sequencer for a chain of up to RANGES_MAX `word_gen_char_range` instances, all clocked from one clock (their CONF_CLK and OP_CLK both tie to CLK). It parses a byte stream of range descriptors and drives the per-range configuration strobes. It then steps the shared `op_state` through START, the optional EXTRA_STAGE and NEXT_CHAR, gating word production with downstream flow control. When the most-significant range wraps, it signals completion.

## Interface
- CHAR_BITS, 7: char width; 7 or 8.
- CHARS_NUMBER_MAX, 96 (224 when CHAR_BITS=8): max chars per range.
- RANGES_MAX, 8: number of range instances driven.
- EXTRA_REGISTER_STAGE, 0: must match the range instances; 1 inserts OP_STATE_EXTRA_STAGE.
- WORD_CNT_WIDTH, 32: width of the generated-word counter.

Ports:
- CLK  in  1  sole clock.
- RESET_N  in  1  asynchronous, active-low reset.
- din  in  8  configuration byte.
- din_wr_en  in  1  byte valid; accepted when din_ready=1.
- din_ready  out  1  controller can accept a byte.
- conf_din  out  CHAR_BITS  registered data to all ranges (`din` of each range).
- conf_en_num_chars  out  RANGES_MAX  one-hot per range.
- num_chars_eq0, num_chars_lt2  out  1 each  qualifiers for conf_en_num_chars.
- conf_en_start_idx  out  RANGES_MAX  one-hot.
- start_idx_is_end  out  1  qualifier for conf_en_start_idx.
- conf_en_chars  out  RANGES_MAX  one-hot.
- conf_char_addr  out  CHAR_BITS  char write address.
- pre_end_char  out  1  char at addr = num_chars-2.
- op_state  out  3  READY=0, START=1, EXTRA_STAGE=2, NEXT_CHAR=3, NEXT_WORD=4.
- op_en  out  1  shared generation enable.
- carry_first  out  1  carry_in of range 0; constant 1.
- carry_last  in  1  carry output of the highest configured range.
- word_ready  in  1  downstream accepts a word this cycle.
- word_valid  out  1  word present on range douts; equals op_en.
- op_done_sync  out  1  one-cycle completion pulse; also drives each range's op_done_sync.
- word_count  out  WORD_CNT_WIDTH  words produced since the last config start.
- error  out  1  sticky format error.

## Operation
- Stream format: N = num_ranges (1..RANGES_MAX). Then, for each range r = 0..N-1: num_chars (0..CHARS_NUMBER_MAX), start_idx, then num_chars char bytes.
- Unconfigured ranges r ≥ N keep their reset/op_done defaults, with num_chars_eq0 = 1.
- States:
  - IDLE: wait for N.
  - NUM_CHARS: pulse conf_en_num_chars[r] with eq0 = (n==0) and lt2 = (n<2).
  - START_IDX: pulse conf_en_start_idx[r] with is_end = (s == n-1).
  - CHARS: k = 0..n-1. Pulse conf_en_chars[r] with addr = k and pre_end_char = (k == n-2).
  - After the last char (or directly when n = 0): r+1. Go to NUM_CHARS while r+1 < N, otherwise OP_START.
  - OP_START, then OP_EXTRA (only if EXTRA_REGISTER_STAGE), then RUN, then DONE, then IDLE.
- Errors: N = 0, N > RANGES_MAX, n > CHARS_NUMBER_MAX, or s ≥ n when n > 0. Each sets error and moves to ERR.
  - In ERR: din_ready = 0 and no strobes are driven.
  - ERR is left only by reset.
- din_ready = 1 in IDLE, NUM_CHARS, START_IDX and CHARS; 0 otherwise.
- op_state by state:
  - READY in all config states and DONE.
  - START in OP_START.
  - EXTRA_STAGE in OP_EXTRA.
  - NEXT_CHAR in RUN.
- RUN:
  - op_en = word_ready.
  - word_count increments on each op_en cycle and saturates at all-ones.
  - op_en & carry_last leads to DONE. The word produced on that cycle is the last and is counted.
- DONE: op_done_sync = 1 for one cycle, then IDLE. word_count holds until the next N byte is accepted, then clears to 0.

## Timing
- Reset values: din_ready = 0, all conf_en_* = 0, conf_din = 0, conf_char_addr = 0, qualifiers = 0, op_state = READY, op_en = 0, op_done_sync = 0, error = 0, word_count = 0, state = IDLE.
- din_ready rises on the first CLK after RESET_N deasserts.
- A byte accepted on cycle t produces its strobe, conf_din and qualifiers, all registered, on cycle t+1, for exactly 1 cycle. Back-to-back bytes give back-to-back strobes.
- The last char strobe is at cycle t+1. OP_START is at t+2, OP_EXTRA at t+3 if enabled, and the first RUN cycle follows.
- carry_last is sampled only when op_en = 1 in RUN. Values outside RUN are ignored.
- RESET_N asserted mid-config or mid-RUN returns all outputs to reset values immediately, asynchronously. Partially loaded range RAM contents are don't-care.

## Test plan
- N=1 with n=3, s=0, chars 'a','b','c' (0x61..0x63), word_ready=1 throughout, carry_last modelled from the range:
  - conf_en_chars pulses at addrs 0, 1, 2, with pre_end_char only at addr 1.
  - Exactly 3 op_en cycles, then op_done_sync; word_count = 3.
- N=2 with range 0 n=2 s=1 and range 1 n=1 s=0:
  - start_idx_is_end = 1 for both.
  - num_chars_lt2 = 1 for range 1.
  - One-hot index switches from bit 0 to bit 1.
- Error cases: N=9 with RANGES_MAX=8, and separately n=2 with s=2.
  - error = 1 and din_ready = 0 on the next cycle.
  - No further strobes; reset clears error.
- word_ready toggled 1, 0, 0, 1 in RUN: op_en follows, and word_count advances only on the 1s.
- n=0 range: num_chars_eq0 = 1, no start-idx strobe, no char strobes; the next range starts on the following byte.
- RESET_N pulsed low during CHARS: all outputs are at reset values within the same cycle, and a full reload afterwards succeeds.
